// File: rtl/snake_body_store.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : snake_body_store                                              |
// | Brief    : Ring-buffer snake body store with self-collision scan and a    |
// |            combinational segment query port. Optional grid bounds check   |
// |            enabled by defining SNAKE_BOUNDS_CHECK_EN.                     |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module snake_body_store #(
  parameter int X_BITS   = 6,
  parameter int Y_BITS   = 6,
  parameter int S_LEN_W  = 8,
  parameter int S_ADDR_W = 8,
  parameter int MAX_LEN  = 255,
  parameter int INIT_LEN = 3,
  parameter int GRID_W   = 60,
  parameter int GRID_H   = 40
) (
  input  logic                sys_clk,
  input  logic                sys_reset_n,
  input  logic                init_in,
  input  logic [X_BITS-1:0]   start_x_in,
  input  logic [Y_BITS-1:0]   start_y_in,
  input  logic                step_in,
  input  logic                grow_in,
  input  logic [X_BITS-1:0]   new_head_x_in,
  input  logic [Y_BITS-1:0]   new_head_y_in,
  input  logic [S_ADDR_W-1:0] query_addr_in,
  output logic [X_BITS-1:0]   query_x_out,
  output logic [Y_BITS-1:0]   query_y_out,
  output logic                query_valid_out,
  output logic [X_BITS-1:0]   head_x_out,
  output logic [Y_BITS-1:0]   head_y_out,
  output logic [S_LEN_W-1:0]  length_out,
  output logic                busy_out,
  output logic                collide_out,
  output logic                scan_done_out
);

  localparam int DEPTH = 2 ** S_ADDR_W;
  localparam int XY_W  = X_BITS + Y_BITS;
  localparam int CMP_W = (S_LEN_W > S_ADDR_W) ? S_LEN_W : S_ADDR_W;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;

  logic [XY_W-1:0]     mem_q [DEPTH];
  logic [1:0]          state_q, state_d;
  logic [S_ADDR_W-1:0] head_ptr_q, head_ptr_d;
  logic [S_LEN_W-1:0]  length_q, length_d;
  logic [X_BITS-1:0]   head_x_q, head_x_d;
  logic [Y_BITS-1:0]   head_y_q, head_y_d;
  logic                collide_q, collide_d;
  logic                scan_done_q, scan_done_d;
  logic                oob_q, oob_d;
  logic [S_ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic [S_LEN_W-1:0]  scan_idx_q, scan_idx_d;

  logic                w_wr_en;
  logic [S_ADDR_W-1:0] w_wr_addr;
  logic [XY_W-1:0]     w_wr_data;
  logic [X_BITS-1:0]   w_init_x;
  logic [S_ADDR_W-1:0] w_scan_addr;
  logic                w_scan_hit;
  logic [S_ADDR_W-1:0] w_q_addr;
  logic [XY_W-1:0]     w_q_data;
  logic                w_q_valid;
  logic                w_step_oob;

`ifdef SNAKE_BOUNDS_CHECK_EN
  assign w_step_oob = (32'(new_head_x_in) >= GRID_W) || (32'(new_head_y_in) >= GRID_H);
`else
  logic w_unused_grid;
  assign w_unused_grid = ^{32'(GRID_W), 32'(GRID_H)};
  assign w_step_oob    = 1'b0;
`endif

  // Initial body lies horizontally to the left of the start cell, tail at mem[0].
  assign w_init_x    = start_x_in - X_BITS'(INIT_LEN - 1) + X_BITS'(init_cnt_q);
  assign w_scan_addr = head_ptr_q - S_ADDR_W'(scan_idx_q);
  assign w_scan_hit  = (mem_q[w_scan_addr] == {head_y_q, head_x_q});

  assign w_q_valid = (CMP_W'(query_addr_in) < CMP_W'(length_q));
  assign w_q_addr  = head_ptr_q - query_addr_in;
  assign w_q_data  = mem_q[w_q_addr];

  always_comb begin
    state_d     = state_q;
    head_ptr_d  = head_ptr_q;
    length_d    = length_q;
    head_x_d    = head_x_q;
    head_y_d    = head_y_q;
    collide_d   = collide_q;
    scan_done_d = 1'b0;
    oob_d       = oob_q;
    init_cnt_d  = init_cnt_q;
    scan_idx_d  = scan_idx_q;
    w_wr_en     = 1'b0;
    w_wr_addr   = '0;
    w_wr_data   = '0;

    if (init_in) begin
      state_d    = ST_INIT;
      init_cnt_d = '0;
      length_d   = '0;
      collide_d  = 1'b0;
      oob_d      = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          w_wr_en   = 1'b1;
          w_wr_addr = init_cnt_q;
          w_wr_data = {start_y_in, w_init_x};
          if (init_cnt_q == S_ADDR_W'(INIT_LEN - 1)) begin
            head_ptr_d = init_cnt_q;
            length_d   = S_LEN_W'(INIT_LEN);
            head_x_d   = start_x_in;
            head_y_d   = start_y_in;
            collide_d  = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            init_cnt_d = init_cnt_q + S_ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (step_in) begin
            head_ptr_d = head_ptr_q + S_ADDR_W'(1);
            w_wr_en    = 1'b1;
            w_wr_addr  = head_ptr_q + S_ADDR_W'(1);
            w_wr_data  = {new_head_y_in, new_head_x_in};
            head_x_d   = new_head_x_in;
            head_y_d   = new_head_y_in;
            collide_d  = 1'b0;
            if (grow_in && (length_q < S_LEN_W'(MAX_LEN))) begin
              length_d = length_q + S_LEN_W'(1);
            end
            scan_idx_d = S_LEN_W'(1);
            oob_d      = w_step_oob;
            state_d    = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (oob_q) begin
            collide_d   = 1'b1;
            scan_done_d = 1'b1;
            oob_d       = 1'b0;
            state_d     = ST_IDLE;
          end else if (length_q <= S_LEN_W'(1)) begin
            scan_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else if (w_scan_hit) begin
            collide_d   = 1'b1;
            scan_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else if (scan_idx_q == length_q - S_LEN_W'(1)) begin
            scan_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            scan_idx_d = scan_idx_q + S_LEN_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q     <= ST_INIT;
      head_ptr_q  <= '0;
      length_q    <= '0;
      head_x_q    <= '0;
      head_y_q    <= '0;
      collide_q   <= 1'b0;
      scan_done_q <= 1'b0;
      oob_q       <= 1'b0;
      init_cnt_q  <= '0;
      scan_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      head_ptr_q  <= head_ptr_d;
      length_q    <= length_d;
      head_x_q    <= head_x_d;
      head_y_q    <= head_y_d;
      collide_q   <= collide_d;
      scan_done_q <= scan_done_d;
      oob_q       <= oob_d;
      init_cnt_q  <= init_cnt_d;
      scan_idx_q  <= scan_idx_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_wr_en) begin
      mem_q[w_wr_addr] <= w_wr_data;
    end
  end

  assign query_valid_out = w_q_valid;
  assign query_x_out     = w_q_valid ? w_q_data[X_BITS-1:0] : '0;
  assign query_y_out     = w_q_valid ? w_q_data[XY_W-1:X_BITS] : '0;
  assign head_x_out      = head_x_q;
  assign head_y_out      = head_y_q;
  assign length_out      = length_q;
  assign busy_out        = (state_q != ST_IDLE);
  assign collide_out     = collide_q;
  assign scan_done_out   = scan_done_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_body_store.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_snake_body_store                                           |
// | Brief    : Scoreboard bench for snake_body_store (scan results checked by |
// |            a monitor on scan_done_out; state/query checked directly).     |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_snake_body_store;

  logic       sys_clk = 1'b0;
  logic       sys_reset_n = 1'b0;
  logic       init_in = 1'b0;
  logic [5:0] start_x_in = 6'd30;
  logic [5:0] start_y_in = 6'd20;
  logic       step_in = 1'b0;
  logic       grow_in = 1'b0;
  logic [5:0] new_head_x_in = '0;
  logic [5:0] new_head_y_in = '0;
  logic [7:0] query_addr_in = '0;
  logic [5:0] query_x_out, query_y_out, head_x_out, head_y_out;
  logic       query_valid_out, busy_out, collide_out, scan_done_out;
  logic [7:0] length_out;

  snake_body_store dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .init_in(init_in),
    .start_x_in(start_x_in), .start_y_in(start_y_in),
    .step_in(step_in), .grow_in(grow_in),
    .new_head_x_in(new_head_x_in), .new_head_y_in(new_head_y_in),
    .query_addr_in(query_addr_in), .query_x_out(query_x_out),
    .query_y_out(query_y_out), .query_valid_out(query_valid_out),
    .head_x_out(head_x_out), .head_y_out(head_y_out),
    .length_out(length_out), .busy_out(busy_out),
    .collide_out(collide_out), .scan_done_out(scan_done_out)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic collide;
    int   step_cyc;
    int   lat;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: every scan_done pulse must match the oldest outstanding expectation.
  always @(negedge sys_clk) begin
    if (sys_reset_n && scan_done_out === 1'b1) begin
      exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL scan_done unexpected: got pulse at cycle %0d, required none", cyc);
      end else begin
        e = exp_q.pop_front();
        if (collide_out !== e.collide || (cyc - e.step_cyc) != e.lat) begin
          n_fails++;
          $display("FAIL scan result: got collide=%0b latency=%0d, required collide=%0b latency=%0d",
                   collide_out, cyc - e.step_cyc, e.collide, e.lat);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic chk_q(input logic [7:0] a, input logic v, input logic [5:0] x, input logic [5:0] y);
    query_addr_in = a;
    #1;
    chk($sformatf("query%0d valid", a), 32'(query_valid_out), 32'(v));
    chk($sformatf("query%0d x", a), 32'(query_x_out), 32'(x));
    chk($sformatf("query%0d y", a), 32'(query_y_out), 32'(y));
  endtask

  task automatic chk_state(input string tag, input logic [5:0] x, input logic [5:0] y,
                           input logic [7:0] len, input logic col);
    chk({tag, " head_x"}, 32'(head_x_out), 32'(x));
    chk({tag, " head_y"}, 32'(head_y_out), 32'(y));
    chk({tag, " length"}, 32'(length_out), 32'(len));
    chk({tag, " collide"}, 32'(collide_out), 32'(col));
  endtask

  task automatic do_step(input logic [5:0] x, input logic [5:0] y, input logic g,
                         input logic exp_done, input logic exp_col, input int exp_lat);
    exp_t e;
    @(negedge sys_clk);
    step_in = 1'b1; grow_in = g; new_head_x_in = x; new_head_y_in = y;
    @(posedge sys_clk);
    #1;
    e.collide = exp_col; e.step_cyc = cyc; e.lat = exp_lat;
    if (exp_done) exp_q.push_back(e);
    @(negedge sys_clk);
    step_in = 1'b0; grow_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_out === 1'b1 && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    chk({tag, " idle reached"}, 32'(busy_out), 32'd0);
  endtask

  task automatic do_init(input logic [5:0] x, input logic [5:0] y);
    @(negedge sys_clk);
    start_x_in = x; start_y_in = y; init_in = 1'b1;
    @(negedge sys_clk);
    init_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge sys_clk);
    chk_state("reset", 6'd0, 6'd0, 8'd0, 1'b0);
    chk("reset scan_done", 32'(scan_done_out), 32'd0);
    chk("reset busy", 32'(busy_out), 32'd1);
    chk_q(8'd0, 1'b0, 6'd0, 6'd0);

    // Automatic INIT: busy for exactly three cycles
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    #1 chk("init busy c0", 32'(busy_out), 32'd1);
    chk("init length during", 32'(length_out), 32'd0);
    @(negedge sys_clk); chk("init busy c1", 32'(busy_out), 32'd1);
    @(negedge sys_clk); chk("init busy c2", 32'(busy_out), 32'd1);
    @(negedge sys_clk); chk("init busy c3", 32'(busy_out), 32'd0);
    chk_state("init", 6'd30, 6'd20, 8'd3, 1'b0);
    chk_q(8'd0, 1'b1, 6'd30, 6'd20);
    chk_q(8'd1, 1'b1, 6'd29, 6'd20);
    chk_q(8'd2, 1'b1, 6'd28, 6'd20);
    chk_q(8'd3, 1'b0, 6'd0, 6'd0);

    // Plain move and grow move
    do_step(6'd31, 6'd20, 1'b0, 1'b1, 1'b0, 2);
    wait_idle("step1");
    chk_state("step1", 6'd31, 6'd20, 8'd3, 1'b0);
    chk_q(8'd2, 1'b1, 6'd29, 6'd20);
    do_step(6'd32, 6'd20, 1'b1, 1'b1, 1'b0, 3);
    wait_idle("grow1");
    chk_state("grow1", 6'd32, 6'd20, 8'd4, 1'b0);
    chk_q(8'd3, 1'b1, 6'd29, 6'd20);

    // U-turn into own body
    do_step(6'd32, 6'd21, 1'b1, 1'b1, 1'b0, 4);
    wait_idle("grow2");
    chk_state("grow2", 6'd32, 6'd21, 8'd5, 1'b0);
    do_step(6'd31, 6'd21, 1'b0, 1'b1, 1'b0, 4);
    wait_idle("turn");
    do_step(6'd31, 6'd20, 1'b0, 1'b1, 1'b1, 4);
    wait_idle("bite");
    repeat (2) @(negedge sys_clk);
    chk_state("bite hold", 6'd31, 6'd20, 8'd5, 1'b1);
    do_step(6'd30, 6'd20, 1'b0, 1'b1, 1'b0, 4);
    chk("collide cleared on step", 32'(collide_out), 32'd0);
    wait_idle("clear");
    chk_state("clear", 6'd30, 6'd20, 8'd5, 1'b0);

    // Step pulse during SCAN is ignored
    do_step(6'd29, 6'd20, 1'b0, 1'b1, 1'b0, 4);
    step_in = 1'b1; grow_in = 1'b1; new_head_x_in = 6'd10; new_head_y_in = 6'd10;
    @(negedge sys_clk);
    step_in = 1'b0; grow_in = 1'b0;
    wait_idle("busy step");
    repeat (2) @(negedge sys_clk);
    chk_state("busy step", 6'd29, 6'd20, 8'd5, 1'b0);

    // init during SCAN aborts the scan with no scan_done pulse
    start_x_in = 6'd10; start_y_in = 6'd5;
    do_step(6'd28, 6'd20, 1'b0, 1'b0, 1'b0, 0);
    init_in = 1'b1;
    @(negedge sys_clk);
    init_in = 1'b0;
    chk("abort length", 32'(length_out), 32'd0);
    chk("abort busy", 32'(busy_out), 32'd1);
    wait_idle("reinit");
    repeat (2) @(negedge sys_clk);
    chk_state("reinit", 6'd10, 6'd5, 8'd3, 1'b0);
    chk_q(8'd1, 1'b1, 6'd9, 6'd5);
    chk_q(8'd2, 1'b1, 6'd8, 6'd5);

    // Out-of-grid head
`ifdef SNAKE_BOUNDS_CHECK_EN
    do_step(6'd60, 6'd5, 1'b0, 1'b1, 1'b1, 1);
    wait_idle("oob");
    chk_state("oob", 6'd60, 6'd5, 8'd3, 1'b1);
`else
    do_step(6'd60, 6'd5, 1'b0, 1'b1, 1'b0, 2);
    wait_idle("oob");
    chk_state("oob", 6'd60, 6'd5, 8'd3, 1'b0);
`endif
    chk_q(8'd0, 1'b1, 6'd60, 6'd5);

    // Serpentine growth to saturation; path never revisits a cell
    do_init(6'd2, 6'd0);
    wait_idle("sat init");
    chk_state("sat init", 6'd2, 6'd0, 8'd3, 1'b0);
    for (int n = 3; n < 258; n++) begin
      int row, col, len;
      row = n / 60;
      col = n % 60;
      len = (n + 1 > 255) ? 255 : n + 1;
      do_step(6'((row % 2 == 0) ? col : 59 - col), 6'(row), 1'b1, 1'b1, 1'b0, len - 1);
      wait_idle("sat step");
      chk($sformatf("sat length n=%0d", n), 32'(length_out), 32'(len));
    end
    chk_q(8'd254, 1'b1, 6'd3, 6'd0);
    chk_q(8'd255, 1'b0, 6'd0, 6'd0);

    repeat (4) @(negedge sys_clk);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
